round_checker: RTL and testbench
================================

# round_checker

Game-progress stage of the Genius datapath, directly upstream of the score logic. It runs each round, requesting playback of the current sequence prefix and checking the player's button presses against sequence memory. It also enforces a per-press timeout. It produces `round`, the count of fully matched sequences that the score stage multiplies into the final points, plus end-of-game flags.

## Interface
- `MAX_LEN`, 15: sequence length that wins the game (1..15).
- `TIMEOUT`, 500: cycles allowed between consecutive presses, and between entering INPUT and the first press.
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a new game.
- `button`  in  4: debounced press pulses, one cycle each; bit i = colour i.
- `seq_data`  in  2: colour stored at `seq_addr`; combinational from sequence memory, valid in the same cycle.
- `show_done`  in  1: one-cycle pulse from the display stage when playback has finished.
- `seq_addr`  out  4: sequence-memory address.
- `show_req`  out  1: one-cycle pulse requesting playback of positions 0..`round`.
- `round`  out  4: number of sequences completed in the current game.
- `end_game`  out  1: game over, win or lose.
- `win`  out  1: the game ended by completing `MAX_LEN`.

## Operation
- States:
  - IDLE: after reset.
  - SHOW: playback in progress.
  - INPUT: collecting presses.
  - WIN, LOSE: terminal.
- Registers:
  - `round` (4 bits).
  - `idx` (4 bits), the position being checked; drives `seq_addr` in INPUT.
  - `tmo` counter, wide enough for `TIMEOUT`.
- `start` is accepted in IDLE, WIN or LOSE. On acceptance:
  - `round` and `idx` clear.
  - `end_game` and `win` clear.
  - `show_req` pulses.
  - The FSM enters SHOW.
- `start` is ignored in SHOW and INPUT.
- SHOW: `seq_addr` = 0. `button` presses are ignored. On `show_done`: `idx` and `tmo` clear, and the FSM enters INPUT.
- INPUT: every cycle with `button` == 0, `tmo` increments. When `tmo` reaches `TIMEOUT`-1 with no press, the FSM enters LOSE.
- When `button` != 0 in INPUT, the press is decoded and compared with `seq_data`:
  - Decode: 0001→0, 0010→1, 0100→2, 1000→3.
  - A non-one-hot value (two or more bits set) counts as a wrong press.
  - Wrong press: the FSM enters LOSE.
  - Correct press with `idx` < `round`: `idx` increments and `tmo` clears.
  - Correct press with `idx` == `round`: `round` increments. If the new `round` == `MAX_LEN`, the FSM enters WIN. Otherwise `idx` clears, `show_req` pulses, and the FSM enters SHOW.
- WIN: `end_game` = 1 and `win` = 1.
- LOSE: `end_game` = 1 and `win` = 0.
- `round` holds its final value in both terminal states, so the score stage can read it.
- `round` never exceeds `MAX_LEN`. No wrap-around is possible because `MAX_LEN` ≤ 15.
- `show_done` received outside SHOW is ignored.

## Timing
- All outputs are registered except `seq_addr`, which is a combinational mux of state and `idx`.
- Reset values:
  - state = IDLE.
  - `round` = 0 and `idx` = 0.
  - `seq_addr` = 0.
  - `show_req` = 0, `end_game` = 0, `win` = 0.
- Reset asserted mid-game returns the block to IDLE immediately (asynchronous) and clears all outputs.
- Start latency: `show_req` is high in the cycle after the `start` edge, and the state is SHOW in the same cycle.
- Press-to-response latency is 1 cycle:
  - `round`, `end_game` and `show_req` update on the clock edge that samples the press.
  - `idx` and `seq_addr` advance on that same edge.
- `show_req` is exactly one cycle wide, once per SHOW entry.
- `show_done` coincident with a `button` pulse in SHOW: the button is ignored and the FSM moves to INPUT.
- A press in the same cycle that `tmo` would expire: the press has priority and is evaluated normally.
- `start` coincident with a press in WIN or LOSE: `start` wins.

## Test plan
- Reset mid-INPUT with `round` = 3 → next cycle `round` = 0, `end_game` = 0, `win` = 0, state IDLE, no `show_req`.
- Memory = {2,0,3,1,…}, `start`, `show_done`, press 0100 → `round` = 1 and `show_req` pulses. `show_done`, then press 0100, 0001 → `round` = 2.
- `round` = 2, press 0100 then 0010 (expected 0001) → LOSE, `end_game` = 1, `win` = 0, `round` stays 2.
- `MAX_LEN` = 3, three correct rounds → `round` = 3, `end_game` = 1, `win` = 1, no further `show_req`.
- `TIMEOUT` = 8, enter INPUT with no presses → `end_game` rises exactly 8 cycles after entry. A correct press at cycle 7 instead → no timeout and `tmo` restarts.
- Press 0011 in INPUT → LOSE. Then `start` in LOSE → `round` = 0, flags clear, `show_req` pulses.

Source files
------------

// File: rtl/round_checker.sv
// Genius game-progress stage: sequences playback rounds, checks presses against
// sequence memory, enforces a per-press timeout and reports round / win / lose.
module round_checker #(
  parameter int MAX_LEN = 15,
  parameter int TIMEOUT = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] button,
  input  logic [1:0] seq_data,
  input  logic       show_done,
  output logic [3:0] seq_addr,
  output logic       show_req,
  output logic [3:0] round,
  output logic       end_game,
  output logic       win
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LAST_RND = 4'(MAX_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_SHOW, S_INPUT, S_WIN, S_LOSE} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [TW-1:0] tmo;
  logic          press_ok;
  logic [1:0]    press_col;
  logic          hit;

  // Only a clean one-hot press can match; anything else is a wrong press.
  always_comb begin
    press_ok  = 1'b1;
    press_col = 2'd0;
    case (button)
      4'b0001: press_col = 2'd0;
      4'b0010: press_col = 2'd1;
      4'b0100: press_col = 2'd2;
      4'b1000: press_col = 2'd3;
      default: press_ok  = 1'b0;
    endcase
    hit = press_ok && (press_col == seq_data);
  end

  assign seq_addr = (state == S_INPUT) ? idx : 4'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      round    <= 4'd0;
      idx      <= 4'd0;
      tmo      <= '0;
      show_req <= 1'b0;
      end_game <= 1'b0;
      win      <= 1'b0;
    end else begin
      show_req <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            round    <= 4'd0;
            idx      <= 4'd0;
            tmo      <= '0;
            end_game <= 1'b0;
            win      <= 1'b0;
            show_req <= 1'b1;
            state    <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (show_done) begin
            idx   <= 4'd0;
            tmo   <= '0;
            state <= S_INPUT;
          end
        end
        S_INPUT: begin
          // A press always beats an expiring timeout in the same cycle.
          if (button != 4'd0) begin
            if (!hit) begin
              end_game <= 1'b1;
              win      <= 1'b0;
              state    <= S_LOSE;
            end else if (idx != round) begin
              idx <= idx + 4'd1;
              tmo <= '0;
            end else if (round == LAST_RND) begin
              round    <= round + 4'd1;
              end_game <= 1'b1;
              win      <= 1'b1;
              state    <= S_WIN;
            end else begin
              round    <= round + 4'd1;
              idx      <= 4'd0;
              show_req <= 1'b1;
              state    <= S_SHOW;
            end
          end else if (tmo == TMO_LAST) begin
            end_game <= 1'b1;
            win      <= 1'b0;
            state    <= S_LOSE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_checker.sv
// Bench for round_checker: directed vector table, hand-written corner sequences,
// then randomized play against a game-level reference model.
module tb_round_checker;
  localparam int ML = 3;
  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       show_done = 1'b0;
  logic [3:0] button = 4'd0;
  logic [1:0] seq_data;
  logic [3:0] seq_addr, round;
  logic       show_req, end_game, win;
  logic [1:0] mem [16];

  int vectors = 0;
  int errs = 0;

  // model: phase 0 idle, 1 playback, 2 taking presses, 3 game over
  int   m_phase, m_round, m_pos, m_wait;
  logic m_req, m_end, m_win;

  typedef struct {
    logic       s;
    logic [3:0] b;
    logic       sd;
    logic [3:0] addr;
    logic [3:0] rnd;
    logic       req, eg, w;
  } vec_t;
  vec_t tbl [18];

  always #5 clock = ~clock;
  assign seq_data = mem[seq_addr];

  round_checker #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .button(button),
    .seq_data(seq_data), .show_done(show_done), .seq_addr(seq_addr),
    .show_req(show_req), .round(round), .end_game(end_game), .win(win)
  );

  function automatic logic [10:0] got();
    return {seq_addr, round, show_req, end_game, win};
  endfunction

  function automatic logic [10:0] e(input int a, input int r, input logic q, input logic g, input logic w);
    return {a[3:0], r[3:0], q, g, w};
  endfunction

  function automatic logic [10:0] mexp();
    int a;
    a = (m_phase == 2) ? m_pos : 0;
    return {a[3:0], m_round[3:0], m_req, m_end, m_win};
  endfunction

  task automatic chk(input string nm, input logic [10:0] g, input logic [10:0] x);
    vectors++;
    if (g !== x) begin
      errs++;
      $display("FAIL %s: got addr=%0d round=%0d req=%b end=%b win=%b, want addr=%0d round=%0d req=%b end=%b win=%b",
               nm, g[10:7], g[6:3], g[2], g[1], g[0], x[10:7], x[6:3], x[2], x[1], x[0]);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_round = 0; m_pos = 0; m_wait = 0;
    m_req = 0; m_end = 0; m_win = 0;
  endtask

  // One game step: what should be visible after this cycle's inputs are sampled.
  task automatic model_step(input logic s, input logic [3:0] b, input logic sd);
    logic [1:0] want;
    want  = mem[m_pos];
    m_req = 0;
    case (m_phase)
      1: if (sd) begin m_phase = 2; m_pos = 0; m_wait = 0; end
      2: begin
        if (b == 4'd0) begin
          m_wait++;
          if (m_wait == TO) begin m_phase = 3; m_end = 1; m_win = 0; end
        end else if (b != (4'b0001 << want)) begin
          m_phase = 3; m_end = 1; m_win = 0;
        end else if (m_pos < m_round) begin
          m_pos++; m_wait = 0;
        end else begin
          m_round++;
          if (m_round == ML) begin m_phase = 3; m_end = 1; m_win = 1; end
          else begin m_phase = 1; m_req = 1; end
        end
      end
      default: if (s) begin
        m_phase = 1; m_round = 0; m_pos = 0; m_end = 0; m_win = 0; m_req = 1;
      end
    endcase
  endtask

  task automatic cyc(input logic s, input logic [3:0] b, input logic sd);
    @(negedge clock);
    start = s; button = b; show_done = sd;
    model_step(s, b, sd);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b1; start = 1'b0; button = 4'd0; show_done = 1'b0;
    model_reset();
    #1 chk("async_reset", got(), e(0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    for (int i = 4; i < 16; i++) mem[i] = 2'(i);
    model_reset();

    tbl[0]  = '{1, 4'h0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 4'h0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 4'h4, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 4'h4, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 4'h0, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 4'h4, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{1, 4'h0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 4'h1, 0, 0, 2, 1, 0, 0};
    tbl[9]  = '{0, 4'h0, 1, 0, 2, 0, 0, 0};
    tbl[10] = '{0, 4'h4, 0, 1, 2, 0, 0, 0};
    tbl[11] = '{0, 4'h2, 0, 0, 2, 0, 1, 0};
    tbl[12] = '{0, 4'h0, 1, 0, 2, 0, 1, 0};
    tbl[13] = '{1, 4'h1, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 4'h1, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 4'h3, 0, 0, 0, 0, 1, 0};
    tbl[16] = '{1, 4'h0, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{0, 4'h0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clock);
    #1 chk("reset_state", got(), e(0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].s, tbl[i].b, tbl[i].sd);
      chk($sformatf("table[%0d]", i), got(),
          e(tbl[i].addr, tbl[i].rnd, tbl[i].req, tbl[i].eg, tbl[i].w));
    end

    // Win at MAX_LEN, then no further playback requests.
    cyc(0, 4'h0, 1);
    cyc(0, 4'h4, 0); chk("win_r1", got(), e(0, 1, 1, 0, 0));
    cyc(0, 4'h0, 1);
    cyc(0, 4'h4, 0); chk("win_r2a", got(), e(1, 1, 0, 0, 0));
    cyc(0, 4'h1, 0); chk("win_r2", got(), e(0, 2, 1, 0, 0));
    cyc(0, 4'h0, 1);
    cyc(0, 4'h4, 0);
    cyc(0, 4'h1, 0); chk("win_r3b", got(), e(2, 2, 0, 0, 0));
    cyc(0, 4'h8, 0); chk("win_final", got(), e(0, 3, 0, 1, 1));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'h0, 0); chk("win_hold", got(), e(0, 3, 0, 1, 1));
    end
    cyc(0, 4'h4, 1); chk("win_press_ignored", got(), e(0, 3, 0, 1, 1));
    cyc(1, 4'h0, 0); chk("restart_from_win", got(), e(0, 0, 1, 0, 0));

    // Timeout expires exactly TO cycles after entering input.
    cyc(0, 4'h0, 1);
    for (int i = 1; i < TO; i++) begin
      cyc(0, 4'h0, 0); chk("tmo_pending", got(), e(0, 0, 0, 0, 0));
    end
    cyc(0, 4'h0, 0); chk("tmo_expire", got(), e(0, 0, 0, 1, 0));

    // Press in the expiring cycle wins and restarts the timer.
    cyc(1, 4'h0, 0);
    cyc(0, 4'h0, 1);
    cyc(0, 4'h4, 0); chk("tmo_r1", got(), e(0, 1, 1, 0, 0));
    cyc(0, 4'h0, 1);
    for (int i = 1; i < TO; i++) cyc(0, 4'h0, 0);
    cyc(0, 4'h4, 0); chk("tmo_press_priority", got(), e(1, 1, 0, 0, 0));
    for (int i = 1; i < TO; i++) begin
      cyc(0, 4'h0, 0); chk("tmo_restarted", got(), e(1, 1, 0, 0, 0));
    end
    cyc(0, 4'h0, 0); chk("tmo_expire2", got(), e(0, 1, 0, 1, 0));

    // Asynchronous reset in the middle of input.
    cyc(1, 4'h0, 0);
    cyc(0, 4'h0, 1); cyc(0, 4'h4, 0);
    cyc(0, 4'h0, 1); cyc(0, 4'h4, 0); cyc(0, 4'h1, 0);
    cyc(0, 4'h0, 1); cyc(0, 4'h4, 0);
    chk("pre_reset", got(), e(1, 2, 0, 0, 0));
    do_reset();
    cyc(0, 4'h0, 0); chk("post_reset_idle", got(), e(0, 0, 0, 0, 0));

    // Randomized play against the model.
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(3));
    begin
      int quiet;
      quiet = 0;
      for (int n = 0; n < 4000; n++) begin
        logic s, sd;
        logic [3:0] b;
        int r;
        r = $urandom_range(99);
        s = 0; sd = 0; b = 4'd0;
        if ($urandom_range(199) == 0) quiet = 12;
        case (m_phase)
          1: begin
            sd = (r < 35);
            s  = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0) b = 4'($urandom_range(15));
          end
          2: begin
            if (r < 65) b = 4'b0001 << mem[m_pos];
            else if (r < 72) b = 4'($urandom_range(15));
            s  = ($urandom_range(19) == 0);
            sd = ($urandom_range(9) == 0);
          end
          default: begin
            s = (r < 25);
            if ($urandom_range(3) == 0) b = 4'($urandom_range(15));
          end
        endcase
        if (quiet > 0) begin quiet--; b = 4'd0; end
        if ($urandom_range(399) == 0) do_reset();
        else begin
          cyc(s, b, sd);
          chk("random", got(), mexp());
        end
      end
    end

    @(negedge clock);
    start = 0; button = 0; show_done = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
